// File: rtl/reaction_timer.sv
// Reaction-time game controller.
// After a start request it fetches a random value, waits a random pre-lamp
// delay, lights the lamp and measures the time to the player's press in ms.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last round's results
//   REQ   | one-cycle trigger pulse to the random number generator
//   LOAD  | capture and clamp the random value, load the pre-lamp delay
//   WAIT  | counting down the pre-lamp delay; a press is a false start
//   ARMED | lamp on, counting reaction ms until press or timeout
//   DONE  | one-cycle wind-down before returning to IDLE
module reaction_timer #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned SCALE_MS     = 20,
    parameter int unsigned MAX_REACT_MS = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        press,
    input  logic [6:0]  rand_in,
    output logic        rand_req,
    output logic        busy,
    output logic        lamp,
    output logic        result_valid,
    output logic [13:0] result_ms,
    output logic        false_start,
    output logic        timeout
);

    // Delay counter sized for the largest possible delay, never below 16 bits.
    localparam int unsigned DLY_MAX  = MIN_DELAY_MS + 99 * SCALE_MS;
    localparam int          DLY_BITS = $clog2(DLY_MAX + 1);
    localparam int          DW       = (DLY_BITS > 16) ? DLY_BITS : 16;
    localparam int          PW       = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [13:0]   REACT_MAX = 14'(MAX_REACT_MS);
    localparam logic [6:0]    RAND_TOP  = 7'd99;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ARMED = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [13:0]   react_q, react_d;
    logic          press_q;
    logic          result_valid_q, result_valid_d;
    logic [13:0]   result_ms_q, result_ms_d;
    logic          false_start_q, false_start_d;
    logic          timeout_q, timeout_d;

    logic          counting;
    logic          tick;
    logic          press_evt;
    logic [6:0]    rand_clamped;
    logic [31:0]   delay_calc;
    logic [13:0]   react_inc;

    assign counting     = (state_q == ST_WAIT) || (state_q == ST_ARMED);
    assign tick         = counting && (pre_q == PRE_LAST);
    assign press_evt    = press && !press_q;
    assign rand_clamped = (rand_in > RAND_TOP) ? RAND_TOP : rand_in;
    assign delay_calc   = 32'(MIN_DELAY_MS) + 32'(rand_clamped) * 32'(SCALE_MS);
    assign react_inc    = react_q + 14'd1;

    // Next-state and datapath decode; a press event always takes priority over
    // a delay expiry or timeout landing on the same tick.
    always_comb begin
        state_d        = state_q;
        pre_d          = pre_q;
        delay_d        = delay_q;
        react_d        = react_q;
        result_valid_d = 1'b0;
        result_ms_d    = result_ms_q;
        false_start_d  = false_start_q;
        timeout_d      = timeout_q;

        if (counting) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_REQ;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            ST_REQ: begin
                if (press_evt) begin
                    false_start_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (press_evt) begin
                    false_start_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    delay_d = DW'(delay_calc);
                    pre_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (press_evt) begin
                    false_start_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (tick) begin
                    // A zero delay (only possible with MIN_DELAY_MS=0) expires on the first tick.
                    if (delay_q <= DW'(1)) begin
                        delay_d = '0;
                        react_d = '0;
                        pre_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            ST_ARMED: begin
                if (press_evt) begin
                    // Count the tick landing on this same cycle so a press on
                    // the last tick reports the full maximum.
                    result_ms_d    = tick ? react_inc : react_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end else if (tick) begin
                    react_d = react_inc;
                    if (react_inc >= REACT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pre_q          <= '0;
            delay_q        <= '0;
            react_q        <= '0;
            press_q        <= 1'b0;
            result_valid_q <= 1'b0;
            result_ms_q    <= '0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            delay_q        <= delay_d;
            react_q        <= react_d;
            press_q        <= press;
            result_valid_q <= result_valid_d;
            result_ms_q    <= result_ms_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
        end
    end

    assign rand_req     = (state_q == ST_REQ);
    assign busy         = (state_q != ST_IDLE);
    assign lamp         = (state_q == ST_ARMED);
    assign result_valid = result_valid_q;
    assign result_ms    = result_ms_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        press;
    logic [6:0]  rand_in;
    logic        rand_req;
    logic        busy;
    logic        lamp;
    logic        result_valid;
    logic [13:0] result_ms;
    logic        false_start;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    reaction_timer #(
        .TICK_DIV     (4),
        .MIN_DELAY_MS (2),
        .SCALE_MS     (1),
        .MAX_REACT_MS (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .press        (press),
        .rand_in      (rand_in),
        .rand_req     (rand_req),
        .busy         (busy),
        .lamp         (lamp),
        .result_valid (result_valid),
        .result_ms    (result_ms),
        .false_start  (false_start),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start with the given random value and advance to the first WAIT cycle.
    task automatic begin_round(input logic [6:0] r);
        rand_in = r;
        start   = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (rand_req !== 1'b1) begin
            errors++;
            $display("FAIL rand_req_pulse: got %0b expected 1", rand_req);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; press = 1'b0; rand_in = 7'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rand_req, busy, lamp, result_valid, false_start, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {rand_req, busy, lamp, result_valid, false_start, timeout});
        end
        checks++;
        if (result_ms !== 14'd0) begin
            errors++;
            $display("FAIL reset_result_ms: got %0d expected 0", result_ms);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_false_start();
        int  n;
        logic lamp_seen;
        begin_round(7'd50);
        lamp_seen = 1'b0;
        for (n = 0; n < 10; n++) begin
            step();
            if (lamp) lamp_seen = 1'b1;
        end
        press = 1'b1;
        step();
        checks++;
        if (false_start !== 1'b1 || result_valid !== 1'b0 || lamp !== 1'b0 || lamp_seen !== 1'b0) begin
            errors++;
            $display("FAIL false_start_set: got fs=%0b rv=%0b lamp=%0b seen=%0b expected 1 0 0 0",
                     false_start, result_valid, lamp, lamp_seen);
        end
        press = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || false_start !== 1'b1) begin
            errors++;
            $display("FAIL false_start_sticky: got busy=%0b fs=%0b expected 0 1", busy, false_start);
        end
        rand_in = 7'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (false_start !== 1'b0) begin
            errors++;
            $display("FAIL false_start_clear: got %0b expected 0", false_start);
        end
        n = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        press = 1'b1;
        step();
        checks++;
        if (result_valid !== 1'b1 || result_ms !== 14'd0) begin
            errors++;
            $display("FAIL fs_followup_result: got rv=%0b ms=%0d expected 1 0", result_valid, result_ms);
        end
        press = 1'b0;
        step();
    endtask

    task automatic test_normal();
        int n;
        begin_round(7'd3);
        checks++;
        if (rand_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_wait_entry: got rr=%0b busy=%0b expected 0 1", rand_req, busy);
        end
        n = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL normal_lamp_delay: got %0d cycles expected 20", n);
        end
        repeat (13) step();
        press = 1'b1;
        step();
        checks++;
        if (result_valid !== 1'b1 || result_ms !== 14'd3 || lamp !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_result: got rv=%0b ms=%0d lamp=%0b busy=%0b expected 1 3 0 1",
                     result_valid, result_ms, lamp, busy);
        end
        press = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_ms !== 14'd3) begin
            errors++;
            $display("FAIL normal_back_idle: got busy=%0b rv=%0b ms=%0d expected 0 0 3",
                     busy, result_valid, result_ms);
        end
    endtask

    task automatic test_timeout();
        int   n;
        int   m;
        logic rv_seen;
        begin_round(7'd0);
        n = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL timeout_lamp_delay: got %0d cycles expected 8", n);
        end
        m = 0;
        rv_seen = 1'b0;
        while (lamp === 1'b1 && m < 1000) begin
            step();
            m++;
            if (result_valid) rv_seen = 1'b1;
        end
        checks++;
        if (m !== 40) begin
            errors++;
            $display("FAIL timeout_lamp_width: got %0d cycles expected 40", m);
        end
        checks++;
        if (timeout !== 1'b1 || result_ms !== 14'd3 || rv_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got to=%0b ms=%0d rv_seen=%0b expected 1 3 0",
                     timeout, result_ms, rv_seen);
        end
        step();
    endtask

    task automatic test_clamp();
        logic [6:0] vals [2];
        int         n;
        vals[0] = 7'd120;
        vals[1] = 7'd99;
        for (int i = 0; i < 2; i++) begin
            begin_round(vals[i]);
            n = 0;
            while (lamp !== 1'b1 && n < 1000) begin
                step();
                n++;
            end
            checks++;
            if (n !== 404) begin
                errors++;
                $display("FAIL clamp_delay_%0d: got %0d cycles expected 404", vals[i], n);
            end
            press = 1'b1;
            step();
            press = 1'b0;
            step();
        end
    endtask

    task automatic test_wait_expiry_press();
        begin_round(7'd0);
        repeat (7) step();
        press = 1'b1;
        step();
        checks++;
        if (false_start !== 1'b1 || lamp !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL expiry_press: got fs=%0b lamp=%0b busy=%0b rv=%0b expected 1 0 1 0",
                     false_start, lamp, busy, result_valid);
        end
        press = 1'b0;
        step();
    endtask

    task automatic test_max_tick_press();
        int n;
        begin_round(7'd0);
        n = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        repeat (39) step();
        checks++;
        if (lamp !== 1'b1) begin
            errors++;
            $display("FAIL max_tick_lamp: got %0b expected 1", lamp);
        end
        press = 1'b1;
        step();
        checks++;
        if (result_valid !== 1'b1 || result_ms !== 14'd10 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL max_tick_press: got rv=%0b ms=%0d to=%0b expected 1 10 0",
                     result_valid, result_ms, timeout);
        end
        press = 1'b0;
        step();
    endtask

    task automatic test_ignored_start_and_reset();
        int n;
        int rq;
        begin_round(7'd0);
        n  = 0;
        rq = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            start = (n == 2);
            step();
            start = 1'b0;
            n++;
            if (rand_req) rq++;
        end
        checks++;
        if (n !== 8 || rq !== 0) begin
            errors++;
            $display("FAIL start_ignored_wait: got %0d cycles %0d req expected 8 0", n, rq);
        end
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (lamp !== 1'b1 || rand_req !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_armed: got lamp=%0b rr=%0b expected 1 0", lamp, rand_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rand_req, busy, lamp, result_valid, false_start, timeout} !== 6'b0 || result_ms !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b ms=%0d expected 000000 0",
                     {rand_req, busy, lamp, result_valid, false_start, timeout}, result_ms);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        begin_round(7'd0);
        n = 0;
        while (lamp !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        repeat (5) step();
        press = 1'b1;
        step();
        checks++;
        if (result_valid !== 1'b1 || result_ms !== 14'd1 || n !== 8) begin
            errors++;
            $display("FAIL post_reset_round: got rv=%0b ms=%0d delay=%0d expected 1 1 8",
                     result_valid, result_ms, n);
        end
        press = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_false_start();
        test_normal();
        test_timeout();
        test_clamp();
        test_wait_expiry_press();
        test_max_tick_press();
        test_ignored_start_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000: clock cycles per 1 ms tick; legal range >= 2.
REQ-002 Parameter MIN_DELAY_MS, default 1000: fixed part of the random pre-lamp delay, in ms.
REQ-003 Parameter SCALE_MS, default 20: ms added per unit of the random value.
REQ-004 Parameter MAX_REACT_MS, default 9999: reaction timeout in ms; legal range <= 16383.
REQ-005 clk  in  1: single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 start  in  1: round request; a 1-cycle pulse is recommended, sampled only in IDLE.
REQ-008 press  in  1: player button, already synchronized and debounced, level-sensitive.
REQ-009 rand_in  in  7: random value from the rng random_number output, nominally 0..99.
REQ-010 rand_req  out  1: 1-cycle pulse that drives the rng trigger input.
REQ-011 busy  out  1: high in every state except IDLE.
REQ-012 lamp  out  1: "go" indicator; high only in ARMED.
REQ-013 result_valid  out  1: 1-cycle pulse when a valid reaction time is captured.
REQ-014 result_ms  out  14: last reaction time in ms; holds its value until the next valid capture.
REQ-015 false_start  out  1: sticky flag; cleared when a new round is accepted.
REQ-016 timeout  out  1: sticky flag; cleared when a new round is accepted.

Function
REQ-017 States: IDLE, REQ, LOAD, WAIT, ARMED, DONE; state encoding is free.
REQ-018 IDLE: start=1 -> REQ; on the same edge, clear false_start and timeout.
REQ-019 IDLE: start is ignored in every other state.
REQ-020 REQ: rand_req=1 for exactly this cycle; REQ -> LOAD unconditionally.
REQ-021 LOAD: capture rand_in (the rng has advanced by this cycle); clamp values >99 to 99.
REQ-022 LOAD: load delay_cnt = MIN_DELAY_MS + r*SCALE_MS.
REQ-023 LOAD: clear the prescaler; go to WAIT.
REQ-024 delay_cnt is at least 16 bits wide; all arithmetic is unsigned with no truncation for the defaults.
REQ-025 Tick: the prescaler counts 0..TICK_DIV-1 in WAIT and ARMED.
REQ-026 Tick: asserted on the cycle the prescaler wraps, so the first tick comes TICK_DIV cycles after state entry.
REQ-027 Press event: rising edge of press, registered (press=1 while the previous registered press=0).
REQ-028 Press event: a press held across start produces no event.
REQ-029 WAIT: each tick decrements delay_cnt.
REQ-030 WAIT: the tick that brings delay_cnt to 0 -> ARMED, clearing react_cnt and the prescaler.
REQ-031 WAIT: a press event -> set false_start, go to DONE.
REQ-032 WAIT: a press event wins over a simultaneous delay expiry.
REQ-033 REQ/LOAD: a press event in either state is treated as a false start.
REQ-034 ARMED: lamp=1; each tick increments react_cnt.
REQ-035 ARMED: a press event -> result_ms <= react_cnt, result_valid=1 for one cycle, go to DONE.
REQ-036 ARMED: react_cnt reaching MAX_REACT_MS on a tick -> set timeout, go to DONE; result_ms is unchanged.
REQ-037 ARMED: a press event wins over a simultaneous timeout.
REQ-038 DONE: lamp=0, busy=1 for one cycle, then IDLE.
REQ-039 Outputs are registered, except rand_req, busy and lamp, which may decode state directly.

Reset
REQ-040 rst_n=0 asynchronously forces state IDLE.
REQ-041 Reset values: rand_req=0, busy=0, lamp=0, result_valid=0, result_ms=0, false_start=0, timeout=0.
REQ-042 Reset values: counters, prescaler and the registered press all 0.
REQ-043 Reset mid-round aborts the round with no result_valid pulse; the first start after release begins a normal round.

Verification (TICK_DIV=4, MIN_DELAY_MS=2, SCALE_MS=1, MAX_REACT_MS=10)
REQ-044 Normal round: start pulse, rand_in=3 -> rand_req pulses 1 cycle after start; lamp rises 20 cycles after WAIT entry.
REQ-045 Normal round (cont.): press edge 13 cycles after lamp rises -> result_valid pulse, result_ms=3, then IDLE 2 cycles later.
REQ-046 False start: rand_in=50, press edge 10 cycles into WAIT -> false_start=1, lamp never rises, no result_valid; next start clears false_start.
REQ-047 Timeout: rand_in=0, no press -> lamp high exactly 40 cycles, then timeout=1, result_ms keeps its previous value.
REQ-048 Boundaries: rand_in=120 -> delay equals the rand_in=99 case (101 ms).
REQ-049 Boundaries: press edge on the expiry tick in WAIT -> false_start; press edge on the max tick in ARMED -> result_ms=10, no timeout.
REQ-050 Reset/ignored start: rst_n low during ARMED -> all outputs return to reset values immediately; start pulsed while busy -> no effect on the round.
